// File: rtl/uart_rx_8n1_if.sv
// uart_rx_8n1_if: parallel-side bundle between uart_rx_8n1 and its consumer.
//   rx_data   [7:0] received byte, LSB = first data bit on the wire
//   rx_valid        rx_data valid (pulse, or FIFO non-empty level)
//   rx_ready        consumer accepts the head byte (used only with the FIFO build)
//   frame_err       one-cycle pulse: stop bit sampled low
//   overrun         one-cycle pulse: byte dropped because the FIFO was full
// master = receiver side, slave = consumer side.
interface uart_rx_8n1_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (output rx_data, output rx_valid, output frame_err, output overrun,
                  input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  overrun,
                  output rx_ready);
endinterface

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 serial receiver on the 12 MHz system clock.
//   Two-flop synchroniser, start-bit check at half a bit, mid-bit data sampling,
//   stop-bit framing check with a BREAK state so a held-low line reports once.
// Ports:
//   clk12   system clock
//   rst_n   asynchronous active-low reset
//   rx      asynchronous serial input, idle high
//   bus     uart_rx_8n1_if.master: rx_data, rx_valid, rx_ready, frame_err, overrun
// Parameters:
//   CLKS_PER_BIT  clk12 cycles per bit (>= 4)
//   FIFO_DEPTH    receive FIFO entries (power of two, >= 2), FIFO build only
// Build option:
//   `define UART_RX_FIFO_EN  -> FIFO_DEPTH-entry first-word-fall-through FIFO with
//   ready/valid; otherwise rx_valid is a one-cycle pulse and overrun is always 0.
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk12,
  input  logic           rst_n,
  input  logic           rx,
  uart_rx_8n1_if.master  bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_done;
  logic          sample_bit;
  logic          good_byte;
  logic          bad_stop;

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign bit_done = (cnt == LAST_C);

  always_comb begin
    state_nxt  = state;
    sample_bit = 1'b0;
    good_byte  = 1'b0;
    bad_stop   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF_C) state_nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (rx_s) begin
            good_byte = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            bad_stop  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The cycle counter restarts on every state change and also wraps at the end of
  // each bit period, so DATA samples every CLKS_PER_BIT cycles without leaving DATA.
  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || bit_done) cnt <= '0;
      else                                  cnt <= cnt + CW'(1);
      if (state != S_DATA)  bit_idx <= '0;
      else if (sample_bit)  bit_idx <= bit_idx + 3'd1;
      if (sample_bit) shreg <= {rx_s, shreg[7:1]};
    end
  end

  logic frame_err_q;

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= bad_stop;
  end

  assign bus.frame_err = frame_err_q;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            full, pop, push_ok, overrun_q;

  assign full    = (count == CNTW'(FIFO_DEPTH));
  assign pop     = (count != '0) && bus.rx_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok = good_byte && (!full || pop);

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= good_byte && full && !pop;
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.rx_valid = (count != '0);
  assign bus.rx_data  = mem[rd_ptr];
  assign bus.overrun  = overrun_q;
`else
  logic [7:0] data_q;
  logic       valid_q;
  logic       unused_cfg;

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= good_byte;
      if (good_byte) data_q <= shreg;
    end
  end

  assign bus.rx_valid = valid_q;
  assign bus.rx_data  = data_q;
  assign bus.overrun  = 1'b0;
  assign unused_cfg   = bus.rx_ready ^ FIFO_DEPTH[0];
`endif

endmodule
